// File: rtl/disp_hole_fill_if.sv
// disp_hole_fill_if: pixel stream bundle for the disparity hole-filling stage.
//
// Signals:
//   in_valid   - disp_in carries a pixel on this advance
//   disp_in    - {flag[1:0], disparity[DWIDTH-1:0]} from the LR check
//                (flag 00 valid, 10 occlusion, 01/11 mismatch)
//   out_valid  - disp_out carries a pixel
//   disp_out   - filled disparity
//   out_filled - disp_out was substituted from a neighbour
//   out_flag   - original flag of the emitted pixel
//
// Handshake: there is no backpressure. A pixel is transferred on every
// advance (clken && en) on which in_valid is high. Outputs are registered,
// change only on advances, and are meaningful while out_valid is high.
//
// Modports: master = producer/consumer around the stage, slave = the stage.
interface disp_hole_fill_if #(
    parameter int DWIDTH = 16
);
    logic              in_valid;
    logic [DWIDTH+1:0] disp_in;
    logic              out_valid;
    logic [DWIDTH-1:0] disp_out;
    logic              out_filled;
    logic [1:0]        out_flag;

    modport master (
        output in_valid, disp_in,
        input  out_valid, disp_out, out_filled, out_flag
    );

    modport slave (
        input  in_valid, disp_in,
        output out_valid, disp_out, out_filled, out_flag
    );
endinterface

// File: rtl/disp_hole_fill.sv
// disp_hole_fill: scanline hole filling behind the left-right consistency
// check. Invalid pixels (occlusion / mismatch) are replaced by the disparity
// of a valid neighbour on the same scanline. A DEPTH-entry delay line gives
// a bounded lookahead so each pixel can capture its nearest valid right
// neighbour before it is emitted; the nearest valid left neighbour is held
// in a register on the output side.
//
// Parameters:
//   DWIDTH - disparity width (integer [DWIDTH-1:8], fraction [7:0])
//   DEPTH  - delay-line length in advances (must be >= 2)
//   CWIDTH - column counter width
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   clken      - global clock enable
//   en         - block enable; the pipeline advances only when clken && en
//   line_width - pixels per line (2..2^CWIDTH-1), static during a frame
//   bus        - disp_hole_fill_if.slave (pixel in / filled pixel out)
//
// Build option:
//   DISP_HOLE_FILL_MISMATCH_MIN_EN - when defined, mismatch pixels take
//   min(left, right) if both neighbours exist. When undefined, mismatch
//   pixels are filled like occlusions (left first, then right).
//
// Latency is exactly DEPTH advances from input to registered output.
module disp_hole_fill #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 16,
    parameter int CWIDTH = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic              en,
    input  logic [CWIDTH-1:0] line_width,
    disp_hole_fill_if.slave   bus
);
    localparam int TAIL = DEPTH - 1;
    localparam logic [CWIDTH-1:0] COL_ONE = {{(CWIDTH-1){1'b0}}, 1'b1};

    // Delay line. Entry 0 is the head, entry TAIL is the next to be emitted.
    logic              ent_v         [DEPTH];
    logic [1:0]        ent_flag      [DEPTH];
    logic [DWIDTH-1:0] ent_word      [DEPTH];
    logic [DWIDTH-1:0] ent_right     [DEPTH];
    logic              ent_has_right [DEPTH];
    logic              ent_open      [DEPTH];

    logic [CWIDTH-1:0] icol;
    logic [CWIDTH-1:0] ocol;
    logic [DWIDTH-1:0] left;
    logic              has_left;

    logic              out_valid_q;
    logic [DWIDTH-1:0] disp_out_q;
    logic              out_filled_q;
    logic [1:0]        out_flag_q;

    logic              adv;
    logic [1:0]        in_flag;
    logic [DWIDTH-1:0] in_word;
    logic              in_eol;
    logic              cap_en;
    logic [DEPTH-1:0]  cap_take;

    assign adv     = clken && en;
    assign in_flag = bus.disp_in[DWIDTH+1:DWIDTH];
    assign in_word = bus.disp_in[DWIDTH-1:0];
    assign in_eol  = bus.in_valid && (icol == line_width - COL_ONE);
    assign cap_en  = bus.in_valid && (in_flag == 2'b00);

    // Entries still waiting for a right neighbour on this line take the
    // incoming valid word. Only positions 0..TAIL-1 survive the shift, so
    // the tail entry leaving on this advance is deliberately excluded.
    always_comb begin
        cap_take = '0;
        for (int i = 0; i < TAIL; i++) begin
            cap_take[i] = cap_en && ent_open[i] && !ent_has_right[i];
        end
    end

    // ------------------------------------------------------------------
    // Fill decision for the tail entry
    // ------------------------------------------------------------------
    logic [DWIDTH-1:0] lf_word;
    logic              lf_done;
    logic [DWIDTH-1:0] fill_word;
    logic              fill_done;

    // Left-first neighbour choice, shared by occlusions and (by default)
    // mismatches. Right is only consulted at line start, or after a run
    // of invalid pixels from column 0.
    always_comb begin
        lf_word = '0;
        lf_done = 1'b0;
        if (has_left) begin
            lf_word = left;
            lf_done = 1'b1;
        end else if (ent_has_right[TAIL]) begin
            lf_word = ent_right[TAIL];
            lf_done = 1'b1;
        end
    end

    always_comb begin
        fill_word = '0;
        fill_done = 1'b0;
        if (ent_flag[TAIL] == 2'b00) begin
            fill_word = ent_word[TAIL];
        end else if (ent_flag[TAIL] == 2'b10) begin
            fill_word = lf_word;
            fill_done = lf_done;
        end else begin
`ifdef DISP_HOLE_FILL_MISMATCH_MIN_EN
            if (has_left && ent_has_right[TAIL]) begin
                fill_word = (left < ent_right[TAIL]) ? left : ent_right[TAIL];
                fill_done = 1'b1;
            end else begin
                fill_word = lf_word;
                fill_done = lf_done;
            end
`else
            fill_word = lf_word;
            fill_done = lf_done;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Input side: column counter and delay line
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            icol <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_v[i]         <= 1'b0;
                ent_flag[i]      <= 2'b00;
                ent_word[i]      <= '0;
                ent_right[i]     <= '0;
                ent_has_right[i] <= 1'b0;
                ent_open[i]      <= 1'b0;
            end
        end else if (adv) begin
            if (bus.in_valid) begin
                icol <= in_eol ? '0 : icol + COL_ONE;
            end

            // Shift with capture applied first; an EOL push then closes
            // every entry so the next line can never act as a right
            // neighbour.
            for (int i = 1; i < DEPTH; i++) begin
                ent_v[i]         <= ent_v[i-1];
                ent_flag[i]      <= ent_flag[i-1];
                ent_word[i]      <= ent_word[i-1];
                ent_right[i]     <= cap_take[i-1] ? in_word : ent_right[i-1];
                ent_has_right[i] <= ent_has_right[i-1] | cap_take[i-1];
                ent_open[i]      <= ent_open[i-1] & ~in_eol;
            end

            // Bubbles are loaded with v=0; their other fields never reach
            // the outputs.
            ent_v[0]         <= bus.in_valid;
            ent_flag[0]      <= bus.in_valid ? in_flag : 2'b00;
            ent_word[0]      <= bus.in_valid ? in_word : '0;
            ent_right[0]     <= '0;
            ent_has_right[0] <= 1'b0;
            ent_open[0]      <= ~in_eol;
        end
    end

    // ------------------------------------------------------------------
    // Output side: left neighbour, output column, registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ocol         <= '0;
            left         <= '0;
            has_left     <= 1'b0;
            out_valid_q  <= 1'b0;
            disp_out_q   <= '0;
            out_filled_q <= 1'b0;
            out_flag_q   <= 2'b00;
        end else if (adv) begin
            out_valid_q <= ent_v[TAIL];
            if (ent_v[TAIL]) begin
                disp_out_q   <= fill_word;
                out_filled_q <= fill_done;
                out_flag_q   <= ent_flag[TAIL];

                if (ent_flag[TAIL] == 2'b00) begin
                    left     <= ent_word[TAIL];
                    has_left <= 1'b1;
                end

                // End of line on the output side: the left neighbour must
                // not leak into the next line. This overrides the load above.
                if (ocol == line_width - COL_ONE) begin
                    ocol     <= '0;
                    has_left <= 1'b0;
                end else begin
                    ocol <= ocol + COL_ONE;
                end
            end else begin
                disp_out_q   <= '0;
                out_filled_q <= 1'b0;
                out_flag_q   <= 2'b00;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.disp_out   = disp_out_q;
    assign bus.out_filled = out_filled_q;
    assign bus.out_flag   = out_flag_q;
endmodule

// File: tb/tb_disp_hole_fill.sv
// tb_disp_hole_fill: randomized and directed stimulus for disp_hole_fill,
// checked against a scanline-level reference model. Each segment of
// advances is generated up front; the model finds, for every pixel, the
// nearest valid pixel to its left on the same line and the first valid
// pixel to its right on the same line within the lookahead window, and the
// expected output of every advance is queued. Stall cycles (clken or en
// low) must leave the outputs unchanged.
module tb_disp_hole_fill;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 10;
    localparam int MAXN  = 512;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          clken;
    logic          en;
    logic [CW-1:0] line_width;

    always #5 clk = ~clk;

    disp_hole_fill_if #(.DWIDTH(DW)) bus ();

    disp_hole_fill #(
        .DWIDTH(DW),
        .DEPTH (DEPTH),
        .CWIDTH(CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clken     (clken),
        .en        (en),
        .line_width(line_width),
        .bus       (bus)
    );

    // ---------------- scoreboard ----------------
    // Packed expectation: {valid, filled, flag[1:0], word[DW-1:0]}
    logic [DW+3:0] exp_q[$];
    logic [DW+3:0] last_exp;
    int            n_checks;
    int            n_errors;

    // Segment stimulus
    logic          seg_v   [MAXN];
    logic [1:0]    seg_f   [MAXN];
    logic [DW-1:0] seg_w   [MAXN];
    int            seg_line[MAXN];
    int            seg_n;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [DW+3:0] e);
        check_val({tag, ".out_valid"}, 32'(bus.out_valid), 32'(e[DW+3]));
        if (e[DW+3]) begin
            check_val({tag, ".disp_out"},   32'(bus.disp_out),   32'(e[DW-1:0]));
            check_val({tag, ".out_filled"}, 32'(bus.out_filled), 32'(e[DW+2]));
            check_val({tag, ".out_flag"},   32'(bus.out_flag),   32'(e[DW+1:DW]));
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [DW+3:0] model_pixel(input int i);
        logic [DW-1:0] l, r, w;
        logic          has_l, has_r, filled;
        if (seg_f[i] == 2'b00) return {1'b1, 1'b0, 2'b00, seg_w[i]};
        has_l = 1'b0; has_r = 1'b0; l = '0; r = '0;
        for (int j = i - 1; j >= 0; j--) begin
            if (seg_v[j] && seg_line[j] == seg_line[i] && seg_f[j] == 2'b00) begin
                l = seg_w[j]; has_l = 1'b1; break;
            end
        end
        // A right neighbour must arrive within DEPTH-1 advances.
        for (int j = i + 1; j <= i + DEPTH - 1 && j < seg_n; j++) begin
            if (seg_v[j] && seg_line[j] == seg_line[i] && seg_f[j] == 2'b00) begin
                r = seg_w[j]; has_r = 1'b1; break;
            end
        end
        w = '0; filled = 1'b0;
`ifdef DISP_HOLE_FILL_MISMATCH_MIN_EN
        if (seg_f[i] != 2'b10 && has_l && has_r) begin
            w = (l < r) ? l : r; filled = 1'b1;
        end else
`endif
        if (has_l) begin
            w = l; filled = 1'b1;
        end else if (has_r) begin
            w = r; filled = 1'b1;
        end
        return {1'b1, filled, seg_f[i], w};
    endfunction

    task automatic build_expect(input int lw);
        int col, line;
        col = 0; line = 0;
        for (int k = 0; k < seg_n; k++) begin
            if (seg_v[k]) begin
                seg_line[k] = line;
                if (col == lw - 1) begin col = 0; line++; end
                else col++;
            end
        end
        for (int k = 0; k < seg_n; k++) begin
            if (k < DEPTH || !seg_v[k-DEPTH]) exp_q.push_back('0);
            else exp_q.push_back(model_pixel(k - DEPTH));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic seg_clear();
        seg_n = 0;
    endtask

    task automatic seg_push(input logic v, input logic [1:0] f, input logic [DW-1:0] w);
        if (seg_n < MAXN) begin
            seg_v[seg_n] = v; seg_f[seg_n] = f; seg_w[seg_n] = w;
            seg_n++;
        end
    endtask

    task automatic seg_flush();
        for (int k = 0; k < DEPTH; k++) seg_push(1'b0, 2'b00, '0);
    endtask

    function automatic logic [1:0] rand_flag();
        int r;
        r = $urandom_range(0, 99);
        if (r < 60) return 2'b00;
        if (r < 80) return 2'b10;
        if (r < 95) return 2'b01;
        return 2'b11;
    endfunction

    task automatic step_adv(input logic v, input logic [1:0] f, input logic [DW-1:0] w);
        logic [31:0]   rnd;
        logic [DW+3:0] e;
        rnd          = $urandom;
        clken        = 1'b1;
        en           = 1'b1;
        bus.in_valid = v;
        bus.disp_in  = v ? {f, w} : rnd[DW+1:0];
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val("exp_q_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_out("adv", e);
            last_exp = e;
        end
    endtask

    // mode 0: random stall kind, mode 1: en low
    task automatic step_stall(input int mode);
        logic [31:0] rnd;
        int          kind;
        rnd  = $urandom;
        kind = (mode == 1) ? 1 : int'($urandom_range(0, 2));
        clken        = (kind == 1);
        en           = (kind == 0);
        bus.in_valid = rnd[31];
        bus.disp_in  = rnd[DW+1:0];
        @(posedge clk);
        #1;
        check_out("hold", last_exp);
    endtask

    task automatic run_seg(input int lw, input int stall_pct);
        line_width = CW'(lw);
        build_expect(lw);
        for (int k = 0; k < seg_n; k++) begin
            if (int'($urandom_range(0, 99)) < stall_pct) begin
                repeat ($urandom_range(1, 3)) step_stall(0);
            end
            step_adv(seg_v[k], seg_f[k], seg_w[k]);
        end
        check_val("seg_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        logic [31:0] rnd;
        rnd          = $urandom;
        rst          = 1'b1;
        clken        = rnd[0];
        en           = 1'b0;
        bus.in_valid = rnd[1];
        bus.disp_in  = rnd[DW+1:0];
        @(posedge clk);
        #1;
        check_val("rst.out_valid",  32'(bus.out_valid),  32'd0);
        check_val("rst.disp_out",   32'(bus.disp_out),   32'd0);
        check_val("rst.out_filled", 32'(bus.out_filled), 32'd0);
        check_val("rst.out_flag",   32'(bus.out_flag),   32'd0);
        rst      = 1'b0;
        last_exp = '0;
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        clken        = 1'b0;
        en           = 1'b0;
        line_width   = CW'(8);
        bus.in_valid = 1'b0;
        bus.disp_in  = '0;
        last_exp     = '0;
        do_reset();

        // Clean stream, two lines of consecutive disparities.
        seg_clear();
        for (int i = 1; i <= 16; i++) seg_push(1'b1, 2'b00, DW'(i));
        seg_flush();
        run_seg(8, 0);
        do_reset();

        // Occlusion run inside a line uses the left neighbour.
        seg_clear();
        seg_push(1'b1, 2'b00, 16'h0500);
        seg_push(1'b1, 2'b10, 16'hBEEF);
        seg_push(1'b1, 2'b10, 16'h1234);
        seg_push(1'b1, 2'b00, 16'h0900);
        seg_push(1'b1, 2'b00, 16'h0A00);
        seg_push(1'b1, 2'b10, 16'h0001);
        seg_push(1'b1, 2'b01, 16'h0002);
        seg_push(1'b1, 2'b00, 16'h0B00);
        seg_flush();
        run_seg(8, 20);
        do_reset();

        // Mismatch between 0x0700 and 0x0300.
        seg_clear();
        seg_push(1'b1, 2'b00, 16'h0700);
        seg_push(1'b1, 2'b01, 16'hFFFF);
        seg_push(1'b1, 2'b00, 16'h0300);
        for (int i = 0; i < 5; i++) seg_push(1'b1, 2'b00, DW'(16'h0100 * i));
        seg_flush();
        run_seg(8, 0);
        do_reset();

        // Line start uses right only; line end never borrows from next line.
        seg_clear();
        seg_push(1'b1, 2'b01, 16'h7777);
        seg_push(1'b1, 2'b00, 16'h0400);
        for (int i = 0; i < 4; i++) seg_push(1'b1, 2'b00, DW'(16'h0410 + i));
        seg_push(1'b1, 2'b00, 16'h0600);
        seg_push(1'b1, 2'b10, 16'h5555);
        seg_push(1'b1, 2'b00, 16'h0100);
        for (int i = 0; i < 7; i++) seg_push(1'b1, 2'b00, DW'(16'h0200 + i));
        seg_flush();
        run_seg(8, 0);
        do_reset();

        // Whole line occluded; next line's first valid is not used backward.
        seg_clear();
        for (int i = 0; i < 8; i++) seg_push(1'b1, 2'b10, DW'($urandom));
        seg_push(1'b1, 2'b00, 16'h0200);
        for (int i = 0; i < 7; i++) seg_push(1'b1, 2'b00, DW'(16'h0300 + i));
        seg_flush();
        run_seg(8, 0);

        // en low mid-stream, then reset; next pixel is column 0.
        do_reset();
        seg_clear();
        for (int i = 0; i < 7; i++) seg_push(1'b1, rand_flag(), DW'($urandom));
        run_seg(8, 0);
        repeat (5) step_stall(1);
        do_reset();
        seg_clear();
        for (int i = 0; i < 16; i++) seg_push(1'b1, rand_flag(), DW'($urandom));
        seg_flush();
        run_seg(8, 10);
        do_reset();

        // Randomized segments: varying line widths, bubbles and stalls.
        for (int r = 0; r < 12; r++) begin
            int lw;
            lw = (r == 0) ? 2 : int'($urandom_range(2, 12));
            seg_clear();
            for (int k = 0; k < 80; k++) begin
                if ($urandom_range(0, 99) < 15) seg_push(1'b0, 2'b00, '0);
                else seg_push(1'b1, rand_flag(), DW'($urandom_range(0, 16'hFFFF)));
            end
            seg_flush();
            run_seg(lw, 15);
            do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
